// File: rtl/term_pkg.sv
// Shared constants, engine state encoding and character classification for text_terminal.
package term_pkg;

    localparam logic [6:0] CH_BS  = 7'h08;
    localparam logic [6:0] CH_LF  = 7'h0A;
    localparam logic [6:0] CH_FF  = 7'h0C;
    localparam logic [6:0] CH_CR  = 7'h0D;
    localparam logic [6:0] CH_SP  = 7'h20;
    localparam logic [6:0] CH_DEL = 7'h7F;

    typedef enum logic [1:0] {
        StIdle,
        StClrRow,
        StClrAll
    } eng_state_e;

    function automatic logic is_printable(input logic [6:0] c);
        return (c >= CH_SP) && (c != CH_DEL);
    endfunction

endpackage

// File: rtl/font_cp437_8x8.sv
// 8x8 CP437 glyph ROM, combinational read; address = {char, scanline}, bit 7 is the leftmost pixel.
// Reduced glyph set: codes without an entry render blank.
module font_cp437_8x8 (
    input  logic [10:0] addr,
    output logic [7:0]  data
);

    logic [63:0] glyph;

    always_comb begin
        glyph = '0;
        case (addr[10:3])
            8'h41:   glyph = 64'h3078CCCCFCCCCC00;
            8'h42:   glyph = 64'hFC66667C6666FC00;
            8'h51:   glyph = 64'h78CCCCCCDC781C00;
            8'h58:   glyph = 64'hC6C66C38386CC600;
            8'hDB:   glyph = 64'hFFFFFFFFFFFFFFFF;
            default: glyph = '0;
        endcase
        data = glyph[{~addr[2:0], 3'b000} +: 8];
    end

endmodule

// File: rtl/term_fifo.sv
// Synchronous FIFO with asynchronous active-low reset; push and pop may occur in the same cycle.
module term_fifo #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == COUNT_FULL);
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/text_terminal.sv
// Glass-terminal core: input FIFO, control-code engine over a circular frame buffer with
// hardware scroll, and combinational dot video with a blinking underline cursor.
module text_terminal
    import term_pkg::*;
#(
    parameter int unsigned COLS         = 32,
    parameter int unsigned ROWS         = 32,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       ti_valid,
    input  logic [6:0] ti,
    output logic       ti_ready,
    output logic       busy,
    output logic       dot
);

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned AW = CW + RW;
    localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [CW-1:0] COL_MAX   = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX   = RW'(ROWS - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);
    localparam logic [9:0]    H_LIM     = 10'(COLS * 8);
    localparam logic [9:0]    V_LIM     = 10'(ROWS * 8);

    eng_state_e    state_q, state_d;
    logic [CW-1:0] cur_col_q, cur_col_d;
    logic [RW-1:0] cur_row_q, cur_row_d;
    logic [RW-1:0] top_q, top_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [RW-1:0] clr_row_q, clr_row_d;
    logic [BW-1:0] blink_cnt_q;
    logic          blink_phase_q;

    logic [6:0]    fifo_dout;
    logic          fifo_full, fifo_empty, fifo_pop;
    logic          newline;
    logic [RW-1:0] wr_phys_row;
    logic [CW-1:0] col_dec;

    logic [6:0]    fb [ROWS*COLS];
    logic          fb_we;
    logic [AW-1:0] fb_waddr;
    logic [6:0]    fb_wdata;

    term_fifo #(
        .WIDTH(7),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (ti_valid),
        .pop  (fifo_pop),
        .din  (ti),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign ti_ready    = !fifo_full;
    assign busy        = !fifo_empty || (state_q != StIdle);
    assign wr_phys_row = cur_row_q + top_q;
    assign col_dec     = cur_col_q - 1'b1;

    always_comb begin
        state_d   = state_q;
        cur_col_d = cur_col_q;
        cur_row_d = cur_row_q;
        top_d     = top_q;
        clr_cnt_d = clr_cnt_q;
        clr_row_d = clr_row_q;
        fifo_pop  = 1'b0;
        fb_we     = 1'b0;
        fb_waddr  = '0;
        fb_wdata  = CH_SP;
        newline   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (is_printable(fifo_dout)) begin
                        fb_we    = 1'b1;
                        fb_waddr = {wr_phys_row, cur_col_q};
                        fb_wdata = fifo_dout;
                        if (cur_col_q == COL_MAX) begin
                            cur_col_d = '0;
                            newline   = 1'b1;
                        end else begin
                            cur_col_d = cur_col_q + 1'b1;
                        end
                    end else begin
                        case (fifo_dout)
                            CH_CR: begin
                                cur_col_d = '0;
                                newline   = 1'b1;
                            end
                            CH_LF: newline = 1'b1;
                            CH_BS: begin
                                if (cur_col_q != '0) begin
                                    cur_col_d = col_dec;
                                    fb_we     = 1'b1;
                                    fb_waddr  = {wr_phys_row, col_dec};
                                end
                            end
                            CH_FF: begin
                                cur_col_d = '0;
                                cur_row_d = '0;
                                top_d     = '0;
                                clr_cnt_d = '0;
                                state_d   = StClrAll;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            StClrRow: begin
                fb_we     = 1'b1;
                fb_waddr  = {clr_row_q, clr_cnt_q[CW-1:0]};
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q[CW-1:0] == COL_MAX) state_d = StIdle;
            end
            StClrAll: begin
                fb_we     = 1'b1;
                fb_waddr  = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // At the bottom line, scroll by advancing top; the old top row becomes the new bottom.
        if (newline) begin
            if (cur_row_q != ROW_MAX) begin
                cur_row_d = cur_row_q + 1'b1;
            end else begin
                top_d     = top_q + 1'b1;
                clr_row_d = top_q;
                clr_cnt_d = '0;
                state_d   = StClrRow;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StClrAll;
            cur_col_q <= '0;
            cur_row_q <= '0;
            top_q     <= '0;
            clr_cnt_q <= '0;
            clr_row_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_col_q <= cur_col_d;
            cur_row_q <= cur_row_d;
            top_q     <= top_d;
            clr_cnt_q <= clr_cnt_d;
            clr_row_q <= clr_row_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (hpos == '0 && vpos == '0) begin
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fb_we) fb[fb_waddr] <= fb_wdata;
    end

    // Video path: separate asynchronous read port, no clock latency.
    logic          in_region;
    logic [RW-1:0] scr_row, rd_phys_row;
    logic [CW-1:0] scr_col;
    logic [6:0]    rd_char;
    logic [7:0]    font_data;
    logic          glyph_bit, cursor_on;

    assign in_region   = ({1'b0, hpos} < H_LIM) && ({1'b0, vpos} < V_LIM);
    assign scr_row     = vpos[3 +: RW];
    assign scr_col     = hpos[3 +: CW];
    assign rd_phys_row = scr_row + top_q;
    assign rd_char     = fb[{rd_phys_row, scr_col}];
    assign glyph_bit   = font_data[~hpos[2:0]];
    assign cursor_on   = (state_q == StIdle) && blink_phase_q && (vpos[2:0] == 3'd7) &&
                         (scr_row == cur_row_q) && (scr_col == cur_col_q);
    assign dot         = in_region && (glyph_bit || cursor_on);

    font_cp437_8x8 u_font (
        .addr({1'b0, rd_char, vpos[2:0]}),
        .data(font_data)
    );

endmodule

// File: tb/tb_text_terminal.sv
// Directed self-checking bench for text_terminal (32x32, FIFO depth 4, blink every 2 frames).
module tb_text_terminal;

    localparam logic [63:0] GL_A = 64'h3078CCCCFCCCCC00;
    localparam logic [63:0] GL_B = 64'hFC66667C6666FC00;
    localparam logic [63:0] GL_Q = 64'h78CCCCCCDC781C00;
    localparam logic [63:0] GL_X = 64'hC6C66C38386CC600;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] hpos = 9'd511;
    logic [8:0] vpos = 9'd511;
    logic       ti_valid = 1'b0;
    logic [6:0] ti = 7'h00;
    logic       ti_ready, busy, dot;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    text_terminal #(
        .COLS(32),
        .ROWS(32),
        .FIFO_DEPTH(4),
        .BLINK_FRAMES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hpos(hpos),
        .vpos(vpos),
        .ti_valid(ti_valid),
        .ti(ti),
        .ti_ready(ti_ready),
        .busy(busy),
        .dot(dot)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input int h, input int v, output logic d);
        hpos = 9'(h);
        vpos = 9'(v);
        #1;
        d = dot;
        hpos = 9'd511;
        vpos = 9'd511;
    endtask

    task automatic check_cell(input string tag, input int srow, input int scol,
                              input logic [63:0] exp);
        logic [63:0] obs;
        obs = '0;
        tick();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                hpos = 9'(scol * 8 + c);
                vpos = 9'(srow * 8 + r);
                #1;
                obs[(7 - r) * 8 + (7 - c)] = dot;
            end
        end
        hpos = 9'd511;
        vpos = 9'd511;
        check(tag, obs, exp);
    endtask

    task automatic count_dots(output int n);
        n = 0;
        tick();
        for (int v = 0; v < 256; v++) begin
            for (int h = 0; h < 256; h++) begin
                hpos = 9'(h);
                vpos = 9'(v);
                #1;
                if (dot) n++;
            end
        end
        hpos = 9'd511;
        vpos = 9'd511;
    endtask

    task automatic blink_toggle;
        hpos = 9'd0;
        vpos = 9'd0;
        tick();
        tick();
        hpos = 9'd511;
        vpos = 9'd511;
    endtask

    // Returns the number of post-push samples with busy high.
    task automatic send_char(input logic [6:0] c, output int cyc);
        ti_valid = 1'b1;
        ti = c;
        tick();
        ti_valid = 1'b0;
        cyc = 0;
        while (busy && cyc < 3000) begin
            cyc++;
            tick();
        end
    endtask

    task automatic measure_clear(output int cyc, output logic ready_ok);
        cyc = 0;
        ready_ok = 1'b1;
        while (busy && cyc < 3000) begin
            tick();
            cyc++;
            if (!ti_ready) ready_ok = 1'b0;
        end
    endtask

    initial begin
        int   cyc;
        int   sum;
        int   n;
        logic d;
        logic ready_ok;

        #2 reset = 1'b0;
        repeat (3) tick();
        check("reset_busy", busy, 1'b1);
        check("reset_ready", ti_ready, 1'b1);
        reset = 1'b1;
        measure_clear(cyc, ready_ok);
        check("post_reset_clear_cycles", cyc, 1024);
        check("ready_during_clear", ready_ok, 1'b1);
        count_dots(n);
        check("blank_after_reset", n, 0);

        // Q, BS, BS at the home position
        send_char(7'h51, cyc);
        check("q_busy_cycles", cyc, 1);
        check_cell("q_written", 0, 0, GL_Q);
        send_char(7'h08, cyc);
        check("bs_busy_cycles", cyc, 1);
        check_cell("bs_erased", 0, 0, 64'h0);
        send_char(7'h08, cyc);
        blink_toggle();
        pixel(3, 7, d);
        check("cursor_col0_after_bs", d, 1'b1);
        pixel(11, 7, d);
        check("cursor_not_col1", d, 1'b0);
        pixel(3, 3, d);
        check("cursor_cell_scanline3_blank", d, 1'b0);
        blink_toggle();
        pixel(3, 7, d);
        check("cursor_blinks_off", d, 1'b0);

        // "AB" back-to-back
        ti_valid = 1'b1;
        ti = 7'h41;
        tick();
        ti = 7'h42;
        tick();
        ti_valid = 1'b0;
        check("ab_busy_edge1", busy, 1'b1);
        tick();
        check("ab_busy_edge2", busy, 1'b0);
        check_cell("cell_0_0_A", 0, 0, GL_A);
        check_cell("cell_0_1_B", 0, 1, GL_B);
        pixel(258, 1, d);
        check("outside_region_dark", d, 1'b0);
        blink_toggle();
        pixel(20, 7, d);
        check("cursor_col2", d, 1'b1);
        pixel(12, 7, d);
        check("cursor_not_col1_ab", d, 1'b0);
        blink_toggle();
        pixel(20, 7, d);
        check("cursor_col2_off", d, 1'b0);

        // Move to row 31, fill it, wrap into a scroll
        send_char(7'h0D, cyc);
        check("cr_busy_cycles", cyc, 1);
        for (int i = 0; i < 30; i++) send_char(7'h0A, cyc);
        sum = 0;
        for (int i = 0; i < 31; i++) begin
            send_char(7'h41, cyc);
            sum += cyc;
        end
        check("row_fill_busy_cycles", sum, 31);
        send_char(7'h41, cyc);
        check("scroll_busy_cycles", cyc, 33);
        send_char(7'h58, cyc);
        check_cell("x_at_screen_row31", 31, 0, GL_X);
        check_cell("old_row0_cleared", 31, 1, 64'h0);
        check_cell("filled_row_now_row30", 30, 0, GL_A);
        check_cell("screen_row0_blank", 0, 0, 64'h0);

        // Form feed clears and homes
        send_char(7'h0C, cyc);
        check("ff_busy_cycles", cyc, 1025);
        count_dots(n);
        check("blank_after_ff", n, 0);
        send_char(7'h41, cyc);
        check_cell("ff_homes_cursor", 0, 0, GL_A);

        // FF, then fill the FIFO during the clear, then reset mid-clear
        ti_valid = 1'b1;
        ti = 7'h0C;
        tick();
        ti = 7'h41;
        repeat (4) tick();
        check("fifo_full_ready_low", ti_ready, 1'b0);
        ti_valid = 1'b0;
        repeat (494) tick();
        check("busy_mid_clear", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("reset_flush_ready", ti_ready, 1'b1);
        check("reset_busy_mid", busy, 1'b1);
        repeat (2) tick();
        reset = 1'b1;
        measure_clear(cyc, ready_ok);
        check("reclear_cycles", cyc, 1024);
        count_dots(n);
        check("blank_after_reclear", n, 0);
        send_char(7'h42, cyc);
        check_cell("home_after_reset", 0, 0, GL_B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
